color_bbox_tracker: RTL and testbench
=====================================

Name: color_bbox_tracker

Overview:
- Consumer at the far end of the colour-mask video stream produced by the HSV colour detector.
- Takes the mask pixels with their hs/vs/de sync and, for each frame, finds the bounding box and hit count of detected pixels.
- Latches the result at every frame boundary for downstream use, e.g. a target-position reporter or an on-screen box overlay.

Parameters:
- H_ACTIVE, 640, active pixels per line; the x counter saturates at H_ACTIVE-1.
- V_ACTIVE, 480, active lines per frame; the y counter saturates at V_ACTIVE-1.
- COORD_W, 11, width of the x/y coordinates.
- CNT_W, 20, width of the hit-pixel counter.
- MIN_PIXELS, 16, minimum hit count for a frame's box to be reported valid.
- VS_ACTIVE, 1, vs polarity; 1 means vs high marks the vertical sync pulse.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous reset, active-high.
- color_hs  in  1  horizontal sync, carried with the mask stream.
- color_vs  in  1  vertical sync.
- color_de  in  1  active-pixel enable.
- color  in  1  mask pixel: 0 = detected (hit), 1 = background.
- box_x_min  out  COORD_W  latched left edge of the box.
- box_x_max  out  COORD_W  latched right edge.
- box_y_min  out  COORD_W  latched top edge.
- box_y_max  out  COORD_W  latched bottom edge.
- hit_count  out  CNT_W  latched number of hit pixels in the last frame.
- box_valid  out  1  latched box is valid (hit_count >= MIN_PIXELS).
- frame_done  out  1  one-cycle pulse when new results are latched.

Behaviour:
- Reset (synchronous, rst=1 on a clk edge):
  - All outputs go to 0.
  - x/y counters and accumulators are cleared.
  - State goes to WAIT_SYNC.
- Frame-start detection:
  - vs_act = (color_vs == VS_ACTIVE).
  - vs_d is vs_act registered one cycle.
  - Frame start fs = vs_act & ~vs_d.
- Pixel counters:
  - x increments on each cycle with de=1, saturating at H_ACTIVE-1.
  - On the falling edge of de (de_d=1, de=0), x clears and y increments, saturating at V_ACTIVE-1.
  - fs clears both x and y.
- State machine:
  - WAIT_SYNC: ignore pixels. On fs, clear accumulators, go to ACTIVE. No latch happens, so a partial frame after reset is discarded.
  - ACTIVE: on each de=1 & color=0 cycle:
    - xmin = min(xmin, x), xmax = max(xmax, x), ymin = min(ymin, y), ymax = max(ymax, y).
    - cnt = cnt + 1, saturating at 2^CNT_W-1.
    - On fs, go to the latch step and remain in ACTIVE.
- Accumulator clear values: xmin = ymin = all-ones; xmax = ymax = 0; cnt = 0.
- Latch on fs in ACTIVE. In the cycle after the fs sample edge, the outputs update:
  - frame_done = 1 for exactly one cycle.
  - hit_count = cnt.
  - If cnt >= MIN_PIXELS: box_valid = 1 and the four coordinates take the accumulator values.
  - Otherwise: box_valid = 0 and all coordinates = 0.
  - The accumulators are cleared in the same edge.
- Outputs hold their values between latches.
- Simultaneous fs and hit pixel (protocol violation, handled anyway):
  - The latch uses the pre-pixel values.
  - The pixel is counted into the new frame, with x=0, y=0 after the counter clear: min = max = 0, cnt = 1.
- MIN_PIXELS = 0 makes every frame valid. An empty frame then reports coordinates min = all-ones, max = 0 unchanged; this is the documented behaviour.
- color_hs is used only by the overlay; otherwise it is unused.
- Reset mid-frame aborts the accumulation, returns to WAIT_SYNC, and clears all outputs.

Optional Feature:
- Macro: COLOR_BBOX_OVERLAY_EN.
- When defined, add outputs ov_hs, ov_vs, ov_de (1 bit each) and ov_pix (2 bits):
  - The syncs are delayed by exactly 1 clk.
  - ov_pix = {border, color}, registered the same way.
  - border = 1 when box_valid=1 and the current (x,y) lies on the latched rectangle's perimeter: x ∈ {x_min, x_max} with y_min ≤ y ≤ y_max, or y ∈ {y_min, y_max} with x_min ≤ x ≤ x_max.
  - All overlay outputs reset to 0.
- When not defined, these ports and their logic are absent; the behaviour above is unchanged.

Test Plan:
- Reset: assert rst for 3 clks with the stream toggling -> all outputs 0, no frame_done, state WAIT_SYNC.
- Basic box:
  - Setup: H_ACTIVE=8, V_ACTIVE=6, MIN_PIXELS=2; drive a discarded first frame, then a frame with hits at (2,1), (5,4), (3,3).
  - Required response: frame_done pulses 1 cycle after the next fs; box = x 2..5, y 1..4; hit_count=3; box_valid=1.
- Below threshold: one hit at (7,5) with MIN_PIXELS=2 -> box_valid=0, coordinates 0, hit_count=1, frame_done still pulses.
- Empty frame following a valid frame -> box_valid drops to 0, hit_count=0; the previous box is cleared to 0.
- Reset mid-frame:
  - Stimulus: rst asserted for 1 clk during line 3 of frame N.
  - Required response: outputs 0; the next fs produces no frame_done; results resume from the frame after that.
- Overlay (COLOR_BBOX_OVERLAY_EN):
  - Setup: box latched as x 2..5, y 1..4.
  - Required response: during the next frame ov_pix[1]=1 at (2,2) and (4,1), 0 at (3,2), 0 at (6,1); ov_de equals color_de delayed 1 clk.

Source files
------------

// File: rtl/color_bbox_tracker.sv
// Per-frame bounding box and hit count of a colour-mask stream, latched at each frame start.
// Optional overlay outputs (box perimeter marked on the delayed stream) with COLOR_BBOX_OVERLAY_EN.
module color_bbox_tracker #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int COORD_W    = 11,
  parameter int CNT_W      = 20,
  parameter int MIN_PIXELS = 16,
  parameter int VS_ACTIVE  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               color_hs,
  input  logic               color_vs,
  input  logic               color_de,
  input  logic               color,
  output logic [COORD_W-1:0] box_x_min,
  output logic [COORD_W-1:0] box_x_max,
  output logic [COORD_W-1:0] box_y_min,
  output logic [COORD_W-1:0] box_y_max,
  output logic [CNT_W-1:0]   hit_count,
  output logic               box_valid,
  output logic               frame_done
`ifdef COLOR_BBOX_OVERLAY_EN
  ,
  output logic               ov_hs,
  output logic               ov_vs,
  output logic               ov_de,
  output logic [1:0]         ov_pix
`endif
);

  // state     | meaning
  // WAIT_SYNC | after reset, discard pixels until the first frame start
  // ACTIVE    | accumulating the current frame, latch on each frame start
  typedef enum logic {WAIT_SYNC, ACTIVE} state_t;

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);

  state_t             state, state_nxt;
  logic               vs_act, vs_d, fs, de_d, hit;
  logic               latch, acc_clr, acc_upd;
  logic [COORD_W-1:0] x, y, px, py;
  logic [COORD_W-1:0] xmin, xmax, ymin, ymax;
  logic [COORD_W-1:0] xmin_b, xmax_b, ymin_b, ymax_b;
  logic [COORD_W-1:0] xmin_n, xmax_n, ymin_n, ymax_n;
  logic [CNT_W-1:0]   cnt, cnt_b, cnt_n;

  assign vs_act = (color_vs == 1'(VS_ACTIVE));
  assign fs     = vs_act & ~vs_d;
  assign hit    = color_de & ~color;
  // A pixel coinciding with frame start belongs to the new frame at (0,0).
  assign px     = fs ? '0 : x;
  assign py     = fs ? '0 : y;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d <= 1'b0;
      de_d <= 1'b0;
      x    <= '0;
      y    <= '0;
    end else begin
      vs_d <= vs_act;
      de_d <= color_de;
      if (fs) begin
        x <= '0;
        y <= '0;
      end else if (color_de) begin
        if (x != X_LAST) x <= x + 1'b1;
      end else if (de_d) begin
        x <= '0;
        if (y != Y_LAST) y <= y + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_SYNC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    acc_clr   = 1'b0;
    acc_upd   = 1'b0;
    case (state)
      WAIT_SYNC: begin
        if (fs) begin
          acc_clr   = 1'b1;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        latch   = fs;
        acc_clr = fs;
        acc_upd = hit;
      end
      default: state_nxt = WAIT_SYNC;
    endcase
  end

  always_comb begin
    xmin_b = acc_clr ? '1 : xmin;
    xmax_b = acc_clr ? '0 : xmax;
    ymin_b = acc_clr ? '1 : ymin;
    ymax_b = acc_clr ? '0 : ymax;
    cnt_b  = acc_clr ? '0 : cnt;
    xmin_n = (acc_upd && px < xmin_b) ? px : xmin_b;
    xmax_n = (acc_upd && px > xmax_b) ? px : xmax_b;
    ymin_n = (acc_upd && py < ymin_b) ? py : ymin_b;
    ymax_n = (acc_upd && py > ymax_b) ? py : ymax_b;
    cnt_n  = (acc_upd && cnt_b != '1) ? cnt_b + 1'b1 : cnt_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xmin <= '1;
      xmax <= '0;
      ymin <= '1;
      ymax <= '0;
      cnt  <= '0;
    end else begin
      xmin <= xmin_n;
      xmax <= xmax_n;
      ymin <= ymin_n;
      ymax <= ymax_n;
      cnt  <= cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      box_x_min  <= '0;
      box_x_max  <= '0;
      box_y_min  <= '0;
      box_y_max  <= '0;
      hit_count  <= '0;
      box_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= latch;
      if (latch) begin
        hit_count <= cnt;
        if (cnt >= CNT_W'(MIN_PIXELS)) begin
          box_valid <= 1'b1;
          box_x_min <= xmin;
          box_x_max <= xmax;
          box_y_min <= ymin;
          box_y_max <= ymax;
        end else begin
          box_valid <= 1'b0;
          box_x_min <= '0;
          box_x_max <= '0;
          box_y_min <= '0;
          box_y_max <= '0;
        end
      end
    end
  end

`ifdef COLOR_BBOX_OVERLAY_EN
  logic border, on_x, on_y, in_x, in_y;

  assign on_x   = (px == box_x_min) || (px == box_x_max);
  assign on_y   = (py == box_y_min) || (py == box_y_max);
  assign in_x   = (px >= box_x_min) && (px <= box_x_max);
  assign in_y   = (py >= box_y_min) && (py <= box_y_max);
  assign border = box_valid & ((on_x & in_y) | (on_y & in_x));

  always_ff @(posedge clk) begin
    if (rst) begin
      ov_hs  <= 1'b0;
      ov_vs  <= 1'b0;
      ov_de  <= 1'b0;
      ov_pix <= 2'b00;
    end else begin
      ov_hs  <= color_hs;
      ov_vs  <= color_vs;
      ov_de  <= color_de;
      ov_pix <= {border, color};
    end
  end
`else
  logic unused_hs;
  assign unused_hs = color_hs;
`endif

endmodule

// File: tb/tb_color_bbox_tracker.sv
// Directed bench for color_bbox_tracker on an 8x6 frame with MIN_PIXELS=2.
// Overlay checks are compiled in when COLOR_BBOX_OVERLAY_EN is defined.
module tb_color_bbox_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        color_hs = 1'b0, color_vs = 1'b0, color_de = 1'b0, color = 1'b1;
  logic [10:0] box_x_min, box_x_max, box_y_min, box_y_max;
  logic [19:0] hit_count;
  logic        box_valid, frame_done;
`ifdef COLOR_BBOX_OVERLAY_EN
  logic        ov_hs, ov_vs, ov_de;
  logic [1:0]  ov_pix;
`endif

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int fd_before;
  logic fd_now;
  logic [64:0] res;

  always #5 clk = ~clk;

  color_bbox_tracker #(
    .H_ACTIVE(8), .V_ACTIVE(6), .COORD_W(11), .CNT_W(20), .MIN_PIXELS(2), .VS_ACTIVE(1)
  ) dut (
    .clk(clk), .rst(rst),
    .color_hs(color_hs), .color_vs(color_vs), .color_de(color_de), .color(color),
    .box_x_min(box_x_min), .box_x_max(box_x_max),
    .box_y_min(box_y_min), .box_y_max(box_y_max),
    .hit_count(hit_count), .box_valid(box_valid), .frame_done(frame_done)
`ifdef COLOR_BBOX_OVERLAY_EN
    , .ov_hs(ov_hs), .ov_vs(ov_vs), .ov_de(ov_de), .ov_pix(ov_pix)
`endif
  );

  assign res = {box_x_min, box_x_max, box_y_min, box_y_max, hit_count, box_valid};

  function automatic logic [47:0] hb(input int x, input int y);
    logic [47:0] one;
    one = 48'd1;
    return one << (y * 8 + x);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (frame_done === 1'b1) fd_cnt++;
  endtask

  // Vertical sync pulse; fd_now captures the cycle right after the fs edge.
  task automatic vsync(input bit hit_on_fs);
    fd_before = fd_cnt;
    color_vs = 1'b1;
    color_de = hit_on_fs;
    color    = ~hit_on_fs;
    step();
    fd_now   = frame_done;
    color_de = 1'b0;
    color    = 1'b1;
    step();
    color_vs = 1'b0;
    step();
  endtask

  task automatic lines(input logic [47:0] hits, input bit ov_chk, input int rst_line);
    logic exp_b;
    bit   chk_b;
    for (int yy = 0; yy < 6; yy++) begin
      for (int xx = 0; xx < 8; xx++) begin
        color_de = 1'b1;
        color    = ~hits[yy*8+xx];
        if (yy == rst_line && xx == 3) rst = 1'b1;
        step();
        rst = 1'b0;
`ifdef COLOR_BBOX_OVERLAY_EN
        if (ov_chk) begin
          chk_b = 1'b1;
          exp_b = 1'b0;
          if      (xx == 2 && yy == 2) exp_b = 1'b1;
          else if (xx == 4 && yy == 1) exp_b = 1'b1;
          else if (xx == 3 && yy == 2) exp_b = 1'b0;
          else if (xx == 6 && yy == 1) exp_b = 1'b0;
          else chk_b = 1'b0;
          if (chk_b) begin
            checks++;
            if (ov_pix[1] !== exp_b) begin
              errors++;
              $display("FAIL ov_border (%0d,%0d): got %b want %b", xx, yy, ov_pix[1], exp_b);
            end
          end
          checks++;
          if (ov_de !== 1'b1 || ov_pix[0] !== ~hits[yy*8+xx]) begin
            errors++;
            $display("FAIL ov_de_pix (%0d,%0d): got de=%b pix0=%b want de=1 pix0=%b",
                     xx, yy, ov_de, ov_pix[0], ~hits[yy*8+xx]);
          end
        end
`else
        chk_b = ov_chk;
        exp_b = chk_b;
`endif
      end
      color_de = 1'b0;
      color    = 1'b1;
      color_hs = 1'b1;
      step();
`ifdef COLOR_BBOX_OVERLAY_EN
      if (ov_chk) begin
        checks++;
        if (ov_de !== 1'b0) begin
          errors++;
          $display("FAIL ov_de_blank line %0d: got %b want 0", yy, ov_de);
        end
      end
`endif
      step();
      color_hs = 1'b0;
      step();
    end
  endtask

  task automatic check_latch(input string name, input logic [64:0] exp);
    checks++;
    if (fd_now !== 1'b1 || fd_cnt - fd_before != 1) begin
      errors++;
      $display("FAIL %s frame_done: got now=%b pulses=%0d want now=1 pulses=1",
               name, fd_now, fd_cnt - fd_before);
    end
    checks++;
    if (res !== exp) begin
      errors++;
      $display("FAIL %s result: got %h want %h", name, res, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      color_vs = i[0];
      color_de = ~i[0];
      color    = i[1];
      color_hs = i[0];
      step();
      checks++;
      if ({res, frame_done} !== 66'd0) begin
        errors++;
        $display("FAIL reset cycle %0d: got %h want 0", i, {res, frame_done});
      end
`ifdef COLOR_BBOX_OVERLAY_EN
      checks++;
      if ({ov_hs, ov_vs, ov_de, ov_pix} !== 5'd0) begin
        errors++;
        $display("FAIL reset_ov cycle %0d: got %b want 0", i, {ov_hs, ov_vs, ov_de, ov_pix});
      end
`endif
    end
    rst = 1'b0; color_vs = 1'b0; color_de = 1'b0; color = 1'b1; color_hs = 1'b0;
    step();
  endtask

  task automatic test_basic_box();
    lines(hb(0, 0) | hb(7, 5), 1'b0, -1);   // partial frame after reset: discarded
    vsync(1'b0);
    checks++;
    if (fd_cnt != fd_before || res !== 65'd0) begin
      errors++;
      $display("FAIL first_fs: got pulses=%0d res=%h want pulses=0 res=0", fd_cnt - fd_before, res);
    end
    lines(hb(2, 1) | hb(5, 4) | hb(3, 3), 1'b0, -1);
    vsync(1'b0);
    check_latch("basic_box", {11'd2, 11'd5, 11'd1, 11'd4, 20'd3, 1'b1});
  endtask

  task automatic test_overlay_below_threshold();
    lines(hb(7, 5), 1'b1, -1);
    vsync(1'b0);
    check_latch("below_threshold", {11'd0, 11'd0, 11'd0, 11'd0, 20'd1, 1'b0});
  endtask

  task automatic test_min_boundary();
    lines(hb(0, 0) | hb(7, 5), 1'b0, -1);
    vsync(1'b0);
    check_latch("min_boundary", {11'd0, 11'd7, 11'd0, 11'd5, 20'd2, 1'b1});
  endtask

  task automatic test_empty_frame();
    lines(48'd0, 1'b0, -1);
    vsync(1'b0);
    check_latch("empty_frame", 65'd0);
  endtask

  task automatic test_back_to_back();
    lines(hb(4, 2) | hb(6, 3), 1'b0, -1);
    vsync(1'b1);   // hit on the fs cycle itself
    check_latch("fs_hit_latch", {11'd4, 11'd6, 11'd2, 11'd3, 20'd2, 1'b1});
    // de falls right after the fs pixel, so stream row 0 is y=1 in this frame.
    lines(hb(1, 0), 1'b0, -1);
    vsync(1'b0);
    check_latch("fs_hit_next", {11'd0, 11'd1, 11'd0, 11'd1, 20'd2, 1'b1});
  endtask

  task automatic test_reset_mid_frame();
    fd_before = fd_cnt;
    lines(hb(1, 1) | hb(6, 4), 1'b0, 3);
    checks++;
    if (res !== 65'd0 || fd_cnt != fd_before) begin
      errors++;
      $display("FAIL mid_reset_out: got %h pulses=%0d want 0 pulses=0", res, fd_cnt - fd_before);
    end
    vsync(1'b0);
    checks++;
    if (fd_cnt != fd_before || res !== 65'd0) begin
      errors++;
      $display("FAIL mid_reset_fs: got pulses=%0d res=%h want pulses=0 res=0", fd_cnt - fd_before, res);
    end
    lines(hb(2, 1) | hb(5, 4), 1'b0, -1);
    vsync(1'b0);
    check_latch("mid_reset_resume", {11'd2, 11'd5, 11'd1, 11'd4, 20'd2, 1'b1});
  endtask

  initial begin
    test_reset();
    test_basic_box();
    test_overlay_below_threshold();
    test_min_boundary();
    test_empty_frame();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
